// File: rtl/div32_seq_pkg.sv
// -----------------------------------------------------------------------------
// div32_seq_pkg
//   Shared definitions for the sequential restoring divider:
//     - state_t   : FSM state encodings (2-bit) S_IDLE/S_CALC/S_FIX/S_DONE
//     - DIV_WIDTH : default operand width
//     - cnt_width : iteration counter width for a given operand width
//     - CNT_W     : counter width at the default operand width
// -----------------------------------------------------------------------------
package div32_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div32_seq_step.sv
// -----------------------------------------------------------------------------
// div32_seq_step
//   One combinational restoring-division step: shift {rem,q} left by one,
//   trial-subtract the divisor, keep the difference when it does not go
//   negative and shift the outcome bit into the quotient.
// Ports
//   rem      in   WIDTH  partial remainder (always < dvs)
//   q        in   WIDTH  dividend bits still to consume / quotient so far
//   dvs      in   WIDTH  divisor magnitude (non-zero)
//   rem_next out  WIDTH  partial remainder after this step
//   q_next   out  WIDTH  quotient/dividend register after this step
// -----------------------------------------------------------------------------
module div32_seq_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             sub_ok;

  // The shifted remainder is WIDTH+1 bits wide.
  assign rem_sh = {rem, q[WIDTH-1]};

  // Subtract as add with inverted B and carry-in 1; carry-out 1 means no
  // borrow. Only the low WIDTH bits go through the adder: when the top bit
  // of rem_sh is set, rem_sh >= 2^WIDTH > dvs, so the subtraction always
  // succeeds and the low WIDTH bits of the difference are exact because the
  // result is below dvs.
  assign {carry, diff} = {1'b0, rem_sh[WIDTH-1:0]} + {1'b0, ~dvs}
                       + {{WIDTH{1'b0}}, 1'b1};

  assign sub_ok   = rem_sh[WIDTH] | carry;
  assign rem_next = sub_ok ? diff : rem_sh[WIDTH-1:0];
  assign q_next   = {q[WIDTH-2:0], sub_ok};

endmodule

// File: rtl/div32_seq.sv
// -----------------------------------------------------------------------------
// div32_seq
//   Multi-cycle restoring divider for DIV/DIVU/REM/REMU. One trial-subtract
//   per cycle on operand magnitudes, then a sign fix-up cycle.
//
// Handshake: start is sampled only in IDLE. An accepted start raises busy
//   from the next cycle through the CALC and FIX cycles; done then pulses for
//   exactly one cycle with quotient/remainder/div_by_zero valid. start while
//   busy or during the done cycle is ignored and never queued. A zero
//   divisor skips straight to the done cycle.
//
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous, active-high reset
//   start        in   1      request (sampled in IDLE only)
//   is_signed    in   1      1 = two's-complement operands
//   dividend     in   WIDTH  numerator, captured on accept
//   divisor      in   WIDTH  denominator, captured on accept
//   busy         out  1      high in CALC and FIX
//   done         out  1      one-cycle completion pulse
//   quotient     out  WIDTH  held until the next result is written
//   remainder    out  WIDTH  held until the next result is written
//   div_by_zero  out  1      set with done on divisor==0, cleared on accept
// -----------------------------------------------------------------------------
module div32_seq
  import div32_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int                 CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] dvs_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] q_r;
  logic             sign_q_r;
  logic             sign_r_r;

  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             dvs_zero;

  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] q_next;

  // Operand magnitudes. -2^(WIDTH-1) negates to itself, which read as an
  // unsigned value is exactly its magnitude, so no special case is needed.
  assign dvd_neg  = is_signed & dividend[WIDTH-1];
  assign dvs_neg  = is_signed & divisor[WIDTH-1];
  assign dvd_mag  = dvd_neg ? -dividend : dividend;
  assign dvs_mag  = dvs_neg ? -divisor : divisor;
  assign dvs_zero = (divisor == '0);

  div32_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .q        (q_r),
    .dvs      (dvs_r),
    .rem_next (rem_next),
    .q_next   (q_next)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = dvs_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == CNT_LAST) begin
          state_next = S_FIX;
        end
      end
      S_FIX:   state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dvs_r       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt   <= '0;
            dbz_r <= dvs_zero;
            if (dvs_zero) begin
              // Divide-by-zero result: all-ones quotient, raw dividend.
              quotient_r  <= '1;
              remainder_r <= dividend;
            end else begin
              dvs_r    <= dvs_mag;
              q_r      <= dvd_mag;
              rem_r    <= '0;
              sign_q_r <= dvd_neg ^ dvs_neg;
              sign_r_r <= dvd_neg;
            end
          end
        end
        S_CALC: begin
          rem_r <= rem_next;
          q_r   <= q_next;
          cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
        S_FIX: begin
          // Remainder takes the sign of the dividend (truncating division).
          quotient_r  <= sign_q_r ? -q_r : q_r;
          remainder_r <= sign_r_r ? -rem_r : rem_r;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (state == S_CALC) || (state == S_FIX);
  assign done        = (state == S_DONE);
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_div32_seq.sv
// -----------------------------------------------------------------------------
// tb_div32_seq
//   Directed testbench for div32_seq with hand-computed expected values.
// -----------------------------------------------------------------------------
module tb_div32_seq;

  localparam int LAT_LIMIT = 100;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks;
  int n_pass;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // Present operands with start for one edge; returns 1 time unit after the
  // edge that samples start (that edge counts as latency cycle 1).
  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen, starting from lat0 edges already spent.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!done && lat < LAT_LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Full operation with result, latency and done-pulse checks.
  task automatic run_op(input string tag, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int elat);
    int lat;
    launch(sgn, a, b);
    if (elat > 1) check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(1, lat);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edbz));
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int lat;
    int done_seen;
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic unsigned and signed cases
    run_op("u100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run_op("s-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("s7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
    run_op("s-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0, 34);
    run_op("u-big/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 34);

    // Divide by zero, then a normal op clears the flag
    run_op("div0", 1'b0, 32'h1234, 32'd0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1);
    run_op("s-5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    run_op("u9/3 after div0", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // Most-negative boundary
    run_op("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
    run_op("u min/-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 34);

    // Start while busy is ignored
    launch(1'b0, 32'd1000, 32'd3);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    is_signed = 1'b1;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(6, lat);
    check("ignore-start latency", 32'(lat), 32'd34);
    check("ignore-start quotient", quotient, 32'd333);
    check("ignore-start remainder", remainder, 32'd1);

    // Start held through the done cycle: ignored in DONE, accepted in IDLE
    is_signed = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h1000;
    start     = 1'b1;
    @(posedge clk);
    #1;
    check("b2b idle busy", 32'(busy), 32'd0);
    check("b2b idle done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b accept busy", 32'(busy), 32'd1);
    wait_done(1, lat);
    check("b2b latency", 32'(lat), 32'd34);
    check("b2b quotient", quotient, 32'h000D_EADB);
    check("b2b remainder", remainder, 32'h0000_0EEF);

    // Reset in the middle of CALC
    launch(1'b0, 32'd1000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst quotient", quotient, 32'd0);
    check("midrst remainder", remainder, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("midrst no done", 32'(done_seen), 32'd0);
    run_op("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
